// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM states, address constants and
// error-cause encoding used for debug visibility.
package apb_pkg;

    localparam int APB_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_MISALIGN = 3'd1,
        ERR_RANGE    = 3'd2,
        ERR_RO_WRITE = 3'd3,
        ERR_NSE      = 3'd4,
        ERR_PROTO    = 3'd5
    } apb_err_e;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_wait_gen.sv
// Loadable down-counter for APB wait-state insertion; done flags the last
// wait cycle so the owner can move to its ready state on the following edge.
module apb_wait_gen #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Load has priority; the counter never wraps below zero.
    always_comb begin
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_completer_regs.sv
// APB4 completer with a small RW register bank and a read-only status word
// at the top index; decode is latched in the setup phase and held per transfer.
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [2:0]                     PPROT,
    input  logic                           PNSE,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERR,
    input  logic [DATA_WIDTH-1:0]          STATUS_IN,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
    output logic [NUM_REGS-1:0]            WR_PULSE
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_REGS - 1);

    apb_state_e            state_d, state_q;
    apb_err_e              err_d, err_q, dec_err_s;
    logic [IDX_W-1:0]      idx_d, idx_q, idx_s;
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_d, wr_pulse_q;
    logic                  setup_s, access_s, err_s, commit_s;
    logic                  load_s, dec_s, cnt_done_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  unused_s;

    assign setup_s  = PSEL && !PENABLE;
    assign access_s = PSEL && PENABLE;
    assign idx_s    = PADDR[IDX_W+APB_ADDR_LSB-1:APB_ADDR_LSB];
    assign err_s    = (err_q != ERR_NONE);
    assign unused_s = ^PPROT;

    apb_wait_gen #(.CNT_W(4)) u_wait (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (load_s),
        .load_val (4'(WAIT_CYCLES)),
        .dec      (dec_s),
        .done     (cnt_done_s)
    );

    // Address/attribute decode; the first matching cause is reported.
    always_comb begin
        if (PADDR[1:0] != 2'b00) begin
            dec_err_s = ERR_MISALIGN;
        end else if (PADDR >= ADDR_WIDTH'(NUM_REGS * 4)) begin
            dec_err_s = ERR_RANGE;
        end else if (PNSE) begin
            dec_err_s = ERR_NSE;
        end else if (PWRITE && (idx_s == TOP_IDX)) begin
            dec_err_s = ERR_RO_WRITE;
        end else begin
            dec_err_s = ERR_NONE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        dec_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup_s) begin
                    load_s  = 1'b1;
                    err_d   = dec_err_s;
                    idx_d   = idx_s;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end else if (access_s) begin
                    // Access phase without a setup phase: fail it immediately.
                    err_d   = ERR_PROTO;
                    idx_d   = idx_s;
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    dec_s   = 1'b1;
                    state_d = cnt_done_s ? DONE : WAIT;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata_s = (idx_q == TOP_IDX) ? STATUS_IN : regs_q[idx_q];

    // Bus outputs; PREADY is combinational on PSEL/PENABLE in DONE.
    always_comb begin
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        PRDATA   = {DATA_WIDTH{1'b0}};
        commit_s = 1'b0;
        if ((state_q == DONE) && access_s) begin
            PREADY   = 1'b1;
            PSLVERR  = err_s;
            commit_s = PWRITE && !err_s;
            if (!PWRITE && !err_s) begin
                PRDATA = rdata_s;
            end else begin
                PRDATA = {DATA_WIDTH{1'b0}};
            end
        end else begin
            PREADY = 1'b0;
        end
    end

    // Byte-strobed register update and per-register write pulses.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse_d[i] = commit_s && (idx_q == IDX_W'(i));
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_pulse_d[i] && PSTRB[b]) begin
                    regs_d[i][8*b +: 8] = PWDATA[8*b +: 8];
                end else begin
                    regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8];
                end
            end
        end
    end

    // State, decode and register bank flops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            idx_q      <= {IDX_W{1'b0}};
            wr_pulse_q <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Flattened register view; the top slice mirrors the live status word.
    always_comb begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            REG_Q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
        REG_Q[(NUM_REGS-1)*DATA_WIDTH +: DATA_WIDTH] = STATUS_IN;
    end

    assign WR_PULSE = wr_pulse_q;

endmodule
